// File: rtl/onn_pkg.sv
// Shared types for the oscillator neuron bank: run-control FSM states and the
// shortest-direction phase step rule used by every neuron.
package onn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StConverged,
    StTimeout
  } onn_state_e;

  typedef enum logic [1:0] {
    StepHold,
    StepUp,
    StepDown
  } step_e;

  // d is (capture - phase) mod 2^pw; a tie at half a period steps up.
  function automatic step_e phase_step(input logic seen, input int unsigned d,
                                       input int unsigned pw);
    if (!seen || d == 0) return StepHold;
    if (d <= (32'd1 << (pw - 1))) return StepUp;
    return StepDown;
  endfunction

endpackage

// File: rtl/neuron_bank_param_if.sv
// Control and data bundle between a neuron bank and whatever drives it.
interface neuron_bank_param_if #(
    parameter int unsigned N  = 15,
    parameter int unsigned PW = 4,
    parameter int unsigned CW = 7
);
    logic            start;
    logic            tick;
    logic [N-1:0]    nin;
    logic [N*PW-1:0] phase_in;
    logic [N-1:0]    nout;
    logic [N*PW-1:0] phi_out;
    logic [N-1:0]    state_changed;
    logic            busy;
    logic            converged;
    logic            timeout;
    logic [CW-1:0]   period_cnt;

    modport master (
        output start, tick, nin, phase_in,
        input  nout, phi_out, state_changed, busy, converged, timeout, period_cnt
    );

    modport slave (
        input  start, tick, nin, phase_in,
        output nout, phi_out, state_changed, busy, converged, timeout, period_cnt
    );
endinterface

// File: rtl/onn_phase_neuron.sv
// One phase oscillator: holds its phase, captures the first input edge per
// period and nudges its phase one step toward it at each period boundary.
module onn_phase_neuron
    import onn_pkg::*;
#(
    parameter int unsigned PW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          run_i,
    input  logic          tick_i,
    input  logic          boundary_i,
    input  logic          run_nxt_i,
    input  logic [PW-1:0] gcnt_i,
    input  logic [PW-1:0] gcnt_nxt_i,
    input  logic          nin_i,
    input  logic [PW-1:0] phase_in_i,
    output logic [PW-1:0] phi_o,
    output logic          nout_o,
    output logic          state_changed_o,
    output logic          moved_o
);

    logic [PW-1:0] phi_q, phi_d, phi_step, cap_q, cap_eff, d, diff_nxt;
    logic          nin_q, seen_q, seen_eff, rise, nout_q, sc_q;
    step_e         step;

    always_comb begin
        rise     = run_i & tick_i & nin_i & ~nin_q;
        seen_eff = seen_q | rise;
        // An edge on the boundary cycle still counts for the ending period.
        cap_eff  = (rise & ~seen_q) ? gcnt_i : cap_q;
        d        = cap_eff - phi_q;
        step     = phase_step(seen_eff, 32'(d), PW);
        unique case (step)
            StepUp:   phi_step = phi_q + 1'b1;
            StepDown: phi_step = phi_q - 1'b1;
            default:  phi_step = phi_q;
        endcase
        moved_o = boundary_i & (step != StepHold);
        if (load_i) begin
            phi_d = phase_in_i;
        end else if (boundary_i) begin
            phi_d = phi_step;
        end else begin
            phi_d = phi_q;
        end
        // High for the first half of each period, measured from the neuron's phase.
        diff_nxt = gcnt_nxt_i - phi_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phi_q  <= '0;
            cap_q  <= '0;
            seen_q <= 1'b0;
            nin_q  <= 1'b0;
            nout_q <= 1'b0;
            sc_q   <= 1'b0;
        end else begin
            phi_q  <= phi_d;
            nout_q <= run_nxt_i & ~diff_nxt[PW-1];
            if (tick_i) nin_q <= nin_i;
            if (load_i) begin
                cap_q  <= '0;
                seen_q <= 1'b0;
                sc_q   <= 1'b0;
            end else if (boundary_i) begin
                cap_q  <= '0;
                seen_q <= 1'b0;
                sc_q   <= moved_o;
            end else if (rise & ~seen_q) begin
                cap_q  <= gcnt_i;
                seen_q <= 1'b1;
            end
        end
    end

    assign phi_o           = phi_q;
    assign nout_o          = nout_q;
    assign state_changed_o = sc_q;

endmodule

// File: rtl/neuron_bank_param.sv
// Grid of coupled phase oscillators sharing one phase counter; runs until the
// phases stop moving for a number of periods or a period limit is hit.
module neuron_bank_param
    import onn_pkg::*;
#(
    parameter int unsigned ROWS           = 3,
    parameter int unsigned COLS           = 5,
    parameter int unsigned PW             = 4,
    parameter int unsigned STABLE_PERIODS = 3,
    parameter int unsigned MAX_PERIODS    = 64
) (
    input  logic                sclk,
    input  logic                rst_n,
    neuron_bank_param_if.slave  bus
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned CW = $clog2(MAX_PERIODS + 1);
    localparam int unsigned SW = $clog2(STABLE_PERIODS + 1);

    onn_state_e      state_q;
    logic [PW-1:0]   gcnt_q, gcnt_nxt;
    logic [CW-1:0]   period_cnt_q, period_nxt;
    logic [SW-1:0]   stable_q, stable_nxt;
    logic            busy_q, converged_q, timeout_q;
    logic            load, in_run, boundary, conv_hit, tout_hit, run_nxt, any_moved;
    logic [N-1:0]    moved, nout_w, sc_w;
    logic [N*PW-1:0] phi_w;

    always_comb begin
        load       = bus.start & (state_q != StLoad);
        in_run     = (state_q == StRun);
        boundary   = in_run & bus.tick & (gcnt_q == '1);
        any_moved  = |moved;
        period_nxt = period_cnt_q + 1'b1;
        stable_nxt = any_moved ? '0 : stable_q + 1'b1;
        conv_hit   = boundary & (stable_nxt == SW'(STABLE_PERIODS));
        tout_hit   = boundary & ~conv_hit & (period_nxt == CW'(MAX_PERIODS));
        if (load) begin
            gcnt_nxt = '0;
        end else if (in_run & bus.tick) begin
            gcnt_nxt = gcnt_q + 1'b1;
        end else begin
            gcnt_nxt = gcnt_q;
        end
        run_nxt = ~load & ((state_q == StLoad) | (in_run & ~conv_hit & ~tout_hit));
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gcnt_q       <= '0;
            period_cnt_q <= '0;
            stable_q     <= '0;
            busy_q       <= 1'b0;
            converged_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else if (load) begin
            state_q      <= StLoad;
            gcnt_q       <= '0;
            period_cnt_q <= '0;
            stable_q     <= '0;
            busy_q       <= 1'b1;
            converged_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    state_q <= StRun;
                    busy_q  <= 1'b1;
                end
                StRun: begin
                    gcnt_q <= gcnt_nxt;
                    if (boundary) begin
                        period_cnt_q <= period_nxt;
                        stable_q     <= stable_nxt;
                        if (conv_hit) begin
                            state_q     <= StConverged;
                            busy_q      <= 1'b0;
                            converged_q <= 1'b1;
                        end else if (tout_hit) begin
                            state_q   <= StTimeout;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_neuron
        onn_phase_neuron #(
            .PW(PW)
        ) u_neuron (
            .clk_i           (sclk),
            .rst_ni          (rst_n),
            .load_i          (load),
            .run_i           (in_run),
            .tick_i          (bus.tick),
            .boundary_i      (boundary),
            .run_nxt_i       (run_nxt),
            .gcnt_i          (gcnt_q),
            .gcnt_nxt_i      (gcnt_nxt),
            .nin_i           (bus.nin[i]),
            .phase_in_i      (bus.phase_in[PW*i +: PW]),
            .phi_o           (phi_w[PW*i +: PW]),
            .nout_o          (nout_w[i]),
            .state_changed_o (sc_w[i]),
            .moved_o         (moved[i])
        );
    end

    assign bus.nout          = nout_w;
    assign bus.phi_out       = phi_w;
    assign bus.state_changed = sc_w;
    assign bus.busy          = busy_q;
    assign bus.converged     = converged_q;
    assign bus.timeout       = timeout_q;
    assign bus.period_cnt    = period_cnt_q;

endmodule
